led_blink_ledout: RTL and testbench
===================================

LED_BLINK_LEDOUT -- requirements
Module: led_blink_ledout

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of LED output bits (1..32).
REQ-002 SHALL have parameter PERIOD_W, default 24: width of the blink period register (1..32).
REQ-003 SHALL have parameter RESET_VALUE, default 0: DATA register value after reset.
REQ-004 SHALL have port clk  input  1: single clock; every register in the block is clocked on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port address  input  2: Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1: slave select; qualifies writes only.
REQ-008 SHALL have port write_n  input  1: active-low write strobe.
REQ-009 SHALL have port writedata  input  32: write data.
REQ-010 SHALL have port readdata  output  32: registered read data.
REQ-011 SHALL have port out_port  output  WIDTH: LED drive.

Function
REQ-012 SHALL define a write as chipselect=1 and write_n=0 on a clk edge; the block SHALL never stall and SHALL have no waitrequest.
REQ-013 SHALL implement this register map: 0 DATA (r/w, WIDTH); 1 BLINK_MASK (r/w, WIDTH); 2 PERIOD (r/w, PERIOD_W); 3 CTRL (write bit0=1 restarts the timer; reads return {31'b0, phase}).
REQ-014 SHALL register readdata every cycle from the addressed register, so the read latency is 1 cycle regardless of chipselect; unused upper bits SHALL read 0.
REQ-015 SHALL drive out_port = DATA ^ (BLINK_MASK & {WIDTH{phase}}) combinationally from registers, so a write is visible on out_port the cycle after its edge.
REQ-016 SHALL run a counter of width PERIOD_W; when PERIOD!=0 and counter==PERIOD-1, the next edge SHALL set counter=0 and toggle phase; otherwise counter SHALL increment.
REQ-017 SHALL hold both counter and phase when PERIOD==0 (blink frozen); PERIOD==1 SHALL toggle phase every cycle.
REQ-018 SHALL clear the counter to 0 on a PERIOD write or a CTRL bit0 write, with phase unchanged; this clear SHALL override a toggle in the same cycle.
REQ-019 SHALL truncate writedata to the register width on write; a CTRL write with bit0=0 SHALL have no effect.
REQ-020 SHALL, when a DATA write and a phase toggle coincide, show the new DATA XOR the new phase on out_port the next cycle.

Reset
REQ-021 SHALL, on reset=1 at a clk edge, set DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=0, counter=0, phase=0, and readdata=0; out_port SHALL therefore equal RESET_VALUE.
REQ-022 SHALL give reset priority over a concurrent write; a reset mid-blink SHALL abort the blink with no residual toggle.

Configuration
REQ-023 SHALL compile the blink engine (BLINK_MASK, PERIOD, CTRL, counter, phase) only when LED_BLINK_LEDOUT_BLINK_EN is defined.
REQ-024 SHALL, without LED_BLINK_LEDOUT_BLINK_EN, make out_port = DATA, make addresses 1-3 read 0, and ignore writes to addresses 1-3.

Structure
REQ-025 SHALL place the address constants (ADDR_DATA=0, ADDR_MASK=1, ADDR_PERIOD=2, ADDR_CTRL=3) and the CTRL bit index in shared package led_blink_pkg.
REQ-026 SHALL implement the counter and phase in one sub-module, led_blink_ledout_timer (inputs: period, restart; output: phase).

Verification
REQ-027 SHALL cover reset: with RESET_VALUE=8'hA5, assert reset for 2 cycles -> out_port=8'hA5, readdata=0, and reads at addresses 1-3 return 0.
REQ-028 SHALL cover write/readback: write DATA=32'h1234_5678 -> out_port=8'h78 the next cycle, and a read of address 0 returns 32'h78 one cycle after the address is presented.
REQ-029 SHALL cover blink: DATA=8'h0F, MASK=8'hFF, PERIOD=4 -> out_port alternates 8'h0F/8'hF0 every 4 cycles, and CTRL reads track phase.
REQ-030 SHALL cover boundaries: PERIOD=1 -> toggle every cycle; PERIOD=0 written mid-count -> phase frozen at its current value; PERIOD=3 written in the toggle cycle -> no toggle, counter restarts at 0.
REQ-031 SHALL cover a mid-blink reset: PERIOD=2 running, then reset -> phase=0, out_port=RESET_VALUE, and no toggle for 2 cycles after reset is released.
REQ-032 SHALL cover the configuration without the macro: write MASK=8'hFF, PERIOD=2 -> out_port stays equal to DATA, and addresses 1-3 read 0.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared register map and write-decode helper for the LED blink peripheral.
package led_blink_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_MASK   = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int CTRL_RESTART_BIT = 0;
   localparam int BUS_W            = 32;

   typedef struct packed {
      logic data;
      logic mask;
      logic period;
      logic restart;
   } wr_dec_t;

   function automatic wr_dec_t decode_write(input logic [1:0] addr,
                                            input logic       wr_en,
                                            input logic       restart_bit);
      wr_dec_t dec;
      dec         = '0;
      dec.data    = wr_en && (addr == ADDR_DATA);
      dec.mask    = wr_en && (addr == ADDR_MASK);
      dec.period  = wr_en && (addr == ADDR_PERIOD);
      dec.restart = wr_en && (addr == ADDR_CTRL) && restart_bit;
      return dec;
   endfunction

endpackage

// File: rtl/led_blink_ledout_timer.sv
// Blink timer: counts 0..period-1 and toggles phase on wrap; period==0 freezes it.
module led_blink_ledout_timer #(
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PERIOD_W-1:0] period,
   input  logic                restart,
   output logic                phase
);

   logic [PERIOD_W-1:0] count_q, count_d;
   logic                phase_q, phase_d;

   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      if (restart) begin
         count_d = '0;
      end else if (period != '0) begin
         if (count_q == period - PERIOD_W'(1)) begin
            count_d = '0;
            phase_d = ~phase_q;
         end else begin
            count_d = count_q + PERIOD_W'(1);
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         phase_q <= 1'b0;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/led_blink_ledout.sv
// Avalon-MM LED output port with optional hardware blink engine.
// Blink engine is built only when LED_BLINK_LEDOUT_BLINK_EN is defined.
module led_blink_ledout
   import led_blink_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter int          PERIOD_W    = 24,
   parameter logic [31:0] RESET_VALUE = 32'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [WIDTH-1:0] RESET_DATA = RESET_VALUE[WIDTH-1:0];

   logic             wr_en;
   logic             wr_data;
   logic [WIDTH-1:0] data_q, data_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             unused_wd;

   assign wr_en     = chipselect && !write_n;
   assign unused_wd = ^writedata;

   always_comb begin
      data_d = data_q;
      if (wr_data) data_d = writedata[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) data_q <= RESET_DATA;
      else       data_q <= data_d;
   end

`ifdef LED_BLINK_LEDOUT_BLINK_EN
   wr_dec_t             wr_dec;
   logic [WIDTH-1:0]    mask_q, mask_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                phase;

   assign wr_dec  = decode_write(address, wr_en, writedata[CTRL_RESTART_BIT]);
   assign wr_data = wr_dec.data;

   always_comb begin
      mask_d   = mask_q;
      period_d = period_q;
      if (wr_dec.mask)   mask_d   = writedata[WIDTH-1:0];
      if (wr_dec.period) period_d = writedata[PERIOD_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q   <= '0;
         period_q <= '0;
      end else begin
         mask_q   <= mask_d;
         period_q <= period_d;
      end
   end

   // A new period always restarts the count so it never starts above period-1.
   led_blink_ledout_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .period  (period_q),
      .restart (wr_dec.period || wr_dec.restart),
      .phase   (phase)
   );

   assign out_port = data_q ^ (mask_q & {WIDTH{phase}});

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:   readdata_d = BUS_W'(data_q);
         ADDR_MASK:   readdata_d = BUS_W'(mask_q);
         ADDR_PERIOD: readdata_d = BUS_W'(period_q);
         default:     readdata_d = BUS_W'(phase);
      endcase
   end
`else
   assign wr_data  = wr_en && (address == ADDR_DATA);
   assign out_port = data_q;

   always_comb begin
      readdata_d = '0;
      if (address == ADDR_DATA) readdata_d = BUS_W'(data_q);
   end
`endif

   // Read data is registered every cycle; chipselect does not gate reads.
   always_ff @(posedge clk) begin
      if (reset) readdata_q <= '0;
      else       readdata_q <= readdata_d;
   end

   assign readdata = readdata_q;

endmodule

// File: tb/tb_led_blink_ledout.sv
// Self-checking bench for led_blink_ledout; adapts to LED_BLINK_LEDOUT_BLINK_EN.
module tb_led_blink_ledout;

`ifdef LED_BLINK_LEDOUT_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   led_blink_ledout #(
      .WIDTH       (8),
      .PERIOD_W    (24),
      .RESET_VALUE (32'hA5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: phase flips each time the cycles elapsed since the last restart reach a multiple of period.
   logic [7:0]  m_data;
   logic [7:0]  m_mask;
   int          m_period;
   int          m_elapsed;
   logic        m_phase;
   logic [31:0] m_rd;

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return {24'd0, m_data};
         2'd1:    return BLINK ? {24'd0, m_mask} : 32'd0;
         2'd2:    return BLINK ? 32'(m_period) : 32'd0;
         default: return BLINK ? {31'd0, m_phase} : 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      bit wr;
      bit restart;
      wr      = chipselect && !write_n;
      restart = BLINK && wr && (address == 2'd2 || (address == 2'd3 && writedata[0]));
      if (reset) begin
         m_data    <= 8'hA5;
         m_mask    <= 8'h00;
         m_period  <= 0;
         m_elapsed <= 0;
         m_phase   <= 1'b0;
         m_rd      <= 32'd0;
      end else begin
         m_rd <= model_read(address);
         if (wr && address == 2'd0) m_data <= writedata[7:0];
         if (BLINK && wr && address == 2'd1) m_mask <= writedata[7:0];
         if (BLINK && wr && address == 2'd2) m_period <= int'(writedata[23:0]);
         if (restart) begin
            m_elapsed <= 0;
         end else if (m_period != 0) begin
            m_elapsed <= m_elapsed + 1;
            if ((m_elapsed + 1) % m_period == 0) m_phase <= ~m_phase;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_port_model", {24'd0, out_port}, {24'd0, m_data ^ (m_mask & {8{m_phase}})});
         check("readdata_model", readdata, m_rd);
      end
   end

   // Called at a negedge; the write lands on the next posedge and returns at the following negedge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;

      // Reset held for two cycles, then idle reads of every register.
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_out", {24'd0, out_port}, 32'h0000_00A5);
      check("reset_rd", readdata, 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      address = 2'd1;
      @(negedge clk);
      check("rd_addr1_after_reset", readdata, 32'd0);
      address = 2'd2;
      @(negedge clk);
      check("rd_addr2_after_reset", readdata, 32'd0);
      address = 2'd3;
      @(negedge clk);
      check("rd_addr3_after_reset", readdata, 32'd0);
      address = 2'd0;
      @(negedge clk);
      check("rd_data_reset_value", readdata, 32'h0000_00A5);

      // Write/readback with truncation.
      bus_write(2'd0, 32'h1234_5678);
      check("data_write_out", {24'd0, out_port}, 32'h0000_0078);
      @(negedge clk);
      check("data_readback", readdata, 32'h0000_0078);

`ifdef LED_BLINK_LEDOUT_BLINK_EN
      // Blink with PERIOD=4.
      bus_write(2'd0, 32'h0F);
      bus_write(2'd1, 32'hFF);
      bus_write(2'd2, 32'd4);
      check("blink_start", {24'd0, out_port}, 32'h0F);
      repeat (3) @(negedge clk);
      check("blink_before_toggle", {24'd0, out_port}, 32'h0F);
      @(negedge clk);
      check("blink_first_toggle", {24'd0, out_port}, 32'hF0);
      address = 2'd3;
      @(negedge clk);
      check("ctrl_phase_1", readdata, 32'd1);
      repeat (3) @(negedge clk);
      check("blink_second_toggle", {24'd0, out_port}, 32'h0F);
      @(negedge clk);
      check("ctrl_phase_0", readdata, 32'd0);

      // PERIOD=1 toggles every cycle.
      bus_write(2'd2, 32'd1);
      check("p1_after_write", {24'd0, out_port}, 32'h0F);
      @(negedge clk);
      check("p1_toggle_a", {24'd0, out_port}, 32'hF0);
      @(negedge clk);
      check("p1_toggle_b", {24'd0, out_port}, 32'h0F);

      // Period write lands on a toggle edge: restart wins.
      bus_write(2'd2, 32'd4);
      check("p4_write_suppresses_toggle", {24'd0, out_port}, 32'h0F);
      repeat (4) @(negedge clk);
      check("p4_toggle", {24'd0, out_port}, 32'hF0);

      // PERIOD=0 mid-count freezes phase at 1.
      bus_write(2'd2, 32'd0);
      check("freeze_now", {24'd0, out_port}, 32'hF0);
      repeat (10) @(negedge clk);
      check("freeze_held", {24'd0, out_port}, 32'hF0);

      // PERIOD=2 then PERIOD=3 written exactly in the toggle cycle.
      bus_write(2'd2, 32'd2);
      check("p2_start", {24'd0, out_port}, 32'hF0);
      repeat (2) @(negedge clk);
      check("p2_toggle", {24'd0, out_port}, 32'h0F);
      @(negedge clk);
      bus_write(2'd2, 32'd3);
      check("p3_write_no_toggle", {24'd0, out_port}, 32'h0F);
      repeat (2) @(negedge clk);
      check("p3_before_toggle", {24'd0, out_port}, 32'h0F);
      @(negedge clk);
      check("p3_toggle", {24'd0, out_port}, 32'hF0);

      // DATA write coinciding with a toggle.
      repeat (2) @(negedge clk);
      bus_write(2'd0, 32'h3C);
      check("data_write_with_toggle", {24'd0, out_port}, 32'h3C);

      // CTRL writes: bit0=0 ignored, bit0=1 restarts.
      bus_write(2'd3, 32'hFFFF_FFFE);
      @(negedge clk);
      bus_write(2'd3, 32'd1);
      repeat (4) @(negedge clk);
`else
      // Blink registers are absent: writes ignored, reads zero.
      bus_write(2'd0, 32'h0F);
      bus_write(2'd1, 32'hFF);
      bus_write(2'd2, 32'd2);
      bus_write(2'd3, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_blink_out_equals_data", {24'd0, out_port}, 32'h0F);
      end
      for (int a = 1; a < 4; a++) begin
         address = 2'(a);
         @(negedge clk);
         check("no_blink_rd_zero", readdata, 32'd0);
      end
`endif

      // Mid-blink reset with a concurrent DATA write.
      bus_write(2'd2, 32'd2);
      repeat (3) @(negedge clk);
      reset      = 1'b1;
      address    = 2'd0;
      writedata  = 32'hFF;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      check("reset_beats_write", {24'd0, out_port}, 32'hA5);
      reset      = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_out", {24'd0, out_port}, 32'hA5);
         check("post_reset_phase", readdata, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
